// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes, iterated unsigned for WIDTH cycles
// (shift-add for multiply, restoring subtract for divide), then sign-corrected.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [4:0]       rd,
  output logic             ready,
  output logic             done,
  output logic [4:0]       w_reg,
  output logic [WIDTH-1:0] w_dat,
  output logic             write
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [2:0]       op_reg;
  logic [4:0]       rd_reg;
  logic [WIDTH-1:0] hi_reg;   // mul: upper product half; div: partial remainder
  logic [WIDTH-1:0] lo_reg;   // mul: multiplier / lower product; div: dividend / quotient
  logic [WIDTH-1:0] b_reg;    // multiplicand or divisor magnitude
  logic             neg_reg;  // negate the final result
  logic             fast_reg; // lo_reg already holds the final answer

  // Operand conditioning at issue: signedness, magnitudes, fast-path detection
  logic             s0_signed, s1_signed, neg0, neg1, neg_issue;
  logic             div_zero, div_ovf, fast_issue;
  logic [WIDTH-1:0] mag0, mag1, fast_res;

  always_comb begin
    s0_signed  = 1'b0;
    s1_signed  = 1'b0;
    fast_res   = '0;
    fast_issue = 1'b0;
    if (!op[2]) begin
      s0_signed = (op[1:0] != 2'd3);
      s1_signed = !op[1];
    end else begin
      s0_signed = !op[0];
      s1_signed = !op[0];
    end
    neg0     = s0_signed & src0[WIDTH-1];
    neg1     = s1_signed & src1[WIDTH-1];
    mag0     = neg0 ? -src0 : src0;
    mag1     = neg1 ? -src1 : src1;
    // the remainder follows the dividend; everything else follows the sign xor
    neg_issue = (op[2] && op[1]) ? neg0 : (neg0 ^ neg1);
    div_zero = (src1 == '0);
    div_ovf  = !op[0] && (src0 == MOST_NEG) && (src1 == '1);
    if (op[2] && div_zero) begin
      fast_issue = 1'b1;
      fast_res   = op[1] ? src0 : '1;
    end else if (op[2] && div_ovf) begin
      fast_issue = 1'b1;
      fast_res   = op[1] ? '0 : src0;
    end
  end

  // One iteration step plus the sign-corrected result of that step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   hi_next, lo_next;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, result;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_reg;
    if (!op_reg[2]) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end else if (div_shift >= {1'b0, b_reg}) begin
      hi_next = div_diff;
      lo_next = {lo_reg[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = div_shift[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], 1'b0};
    end
    prod   = {hi_next, lo_next};
    prod_s = neg_reg ? -prod : prod;
    quo_s  = neg_reg ? -lo_next : lo_next;
    rem_s  = neg_reg ? -hi_next : hi_next;
    if (!op_reg[2])
      result = (op_reg[1:0] == 2'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    else
      result = op_reg[1] ? rem_s : quo_s;
  end

  // Control FSM with registered handshake and write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      write    <= 1'b0;
      w_reg    <= '0;
      w_dat    <= '0;
      op_reg   <= '0;
      rd_reg   <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      b_reg    <= '0;
      neg_reg  <= 1'b0;
      fast_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          write <= 1'b0;
          if (start) begin
            op_reg   <= op;
            rd_reg   <= rd;
            b_reg    <= mag1;
            hi_reg   <= '0;
            lo_reg   <= fast_issue ? fast_res : mag0;
            neg_reg  <= neg_issue;
            fast_reg <= fast_issue;
            count    <= '0;
            ready    <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (fast_reg) begin
            w_dat <= lo_reg;
            w_reg <= rd_reg;
            done  <= 1'b1;
            write <= (rd_reg != 5'd0);
            state <= DONE;
          end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            count  <= count + 1'b1;
            if (count == LAST) begin
              w_dat <= result;
              w_reg <= rd_reg;
              done  <= 1'b1;
              write <= (rd_reg != 5'd0);
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          write <= 1'b0;
          ready <= 1'b1;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
